// File: rtl/dark_frame_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_if
//  Brief    : AXI4-Stream bundle with master/slave views.
//  Revision : 1.0  initial release
// ============================================================================
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 16,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic                       tlast;
    logic                       tuser;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/dark_frame_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dark_frame_gen
//  Brief    : Synthetic dark-frame video source: pedestal plus masked LFSR
//             noise, streamed as full AXI4-Stream frames with blanking.
//  Revision : 1.0  initial release
// ============================================================================
module dark_frame_gen #(
    parameter int          PX_WIDTH     = 10,
    parameter int          FRAME_RES_X  = 1920,
    parameter int          FRAME_RES_Y  = 1080,
    parameter int          BLANK_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [PX_WIDTH-1:0] pedestal_i,
    input  logic [PX_WIDTH-1:0] noise_mask_i,
    output logic                frame_done_o,
    output logic                busy_o,
    axi4_stream_if.master       video_o
);

    localparam int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8;
    localparam int XW = (FRAME_RES_X  > 1) ? $clog2(FRAME_RES_X)  : 1;
    localparam int YW = (FRAME_RES_Y  > 1) ? $clog2(FRAME_RES_Y)  : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_RES_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_RES_Y - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_cnt_q, x_cnt_d;
    logic [YW-1:0]       y_cnt_q, y_cnt_d;
    logic [BW-1:0]       blank_cnt_q, blank_cnt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [PX_WIDTH-1:0] ped_q, ped_d;
    logic [PX_WIDTH-1:0] mask_q, mask_d;
    logic [PX_WIDTH-1:0] px_q, px_d;
    logic                tuser_q, tuser_d;
    logic                tlast_q, tlast_d;
    logic                frame_done_q, frame_done_d;

    logic                tvalid;
    logic                handshake;
    logic                x_last;
    logic                y_last;
    logic [15:0]         lfsr_adv;
    logic                start_frame;
    logic [15:0]         start_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Sum carries one extra bit so overflow saturates instead of wrapping.
    function automatic logic [PX_WIDTH-1:0] calc_px(
        input logic [PX_WIDTH-1:0] ped,
        input logic [PX_WIDTH-1:0] mask,
        input logic [PX_WIDTH-1:0] rnd
    );
        logic [PX_WIDTH:0] sum;
        sum = {1'b0, ped} + {1'b0, rnd & mask};
        return sum[PX_WIDTH] ? {PX_WIDTH{1'b1}} : sum[PX_WIDTH-1:0];
    endfunction

    assign tvalid    = (state_q == ST_ACTIVE);
    assign handshake = tvalid && video_o.tready;
    assign x_last    = (x_cnt_q == X_LAST);
    assign y_last    = (y_cnt_q == Y_LAST);
    assign lfsr_adv  = lfsr_step(lfsr_q);

    always_comb begin
        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        lfsr_d       = lfsr_q;
        ped_d        = ped_q;
        mask_d       = mask_q;
        px_d         = px_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        frame_done_d = 1'b0;
        start_frame  = 1'b0;
        start_lfsr   = lfsr_q;

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (handshake) begin
                    lfsr_d = lfsr_adv;
                    if (x_last) begin
                        x_cnt_d = '0;
                        if (y_last) begin
                            y_cnt_d      = '0;
                            frame_done_d = 1'b1;
                            if (BLANK_CYCLES > 0) begin
                                state_d     = ST_BLANK;
                                blank_cnt_d = '0;
                            end else if (en_i) begin
                                start_frame = 1'b1;
                                start_lfsr  = lfsr_adv;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            y_cnt_d = y_cnt_q + YW'(1);
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + XW'(1);
                    end
                    // Next beat is registered on the same edge: no bubbles.
                    px_d    = calc_px(ped_q, mask_q, lfsr_adv[PX_WIDTH-1:0]);
                    tuser_d = 1'b0;
                    tlast_d = (x_cnt_d == X_LAST);
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == B_LAST) begin
                    blank_cnt_d = '0;
                    if (en_i) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d = ST_ACTIVE;
            x_cnt_d = '0;
            y_cnt_d = '0;
            ped_d   = pedestal_i;
            mask_d  = noise_mask_i;
            px_d    = calc_px(pedestal_i, noise_mask_i, start_lfsr[PX_WIDTH-1:0]);
            tuser_d = 1'b1;
            tlast_d = (FRAME_RES_X == 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            blank_cnt_q  <= '0;
            lfsr_q       <= LFSR_SEED;
            ped_q        <= '0;
            mask_q       <= '0;
            px_q         <= '0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            lfsr_q       <= lfsr_d;
            ped_q        <= ped_d;
            mask_q       <= mask_d;
            px_q         <= px_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign video_o.tvalid = tvalid;
    assign video_o.tdata  = TDATA_WIDTH'(px_q);
    assign video_o.tuser  = tuser_q;
    assign video_o.tlast  = tlast_q;
    assign video_o.tkeep  = {(TDATA_WIDTH/8){tvalid}};
    assign video_o.tstrb  = {(TDATA_WIDTH/8){tvalid}};
    assign video_o.tid    = '0;
    assign video_o.tdest  = '0;

    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
